// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential instruction fetch with a credit-checked prefetch queue and redirect flush
module fetch_prefetch #(
   parameter int XLEN   = 32,
   parameter int QDEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [XLEN-1:0]                  pc_init,
   output logic                             imem_req,
   output logic [XLEN-1:0]                  imem_addr,
   input  logic [XLEN-1:0]                  imem_rdata,
   input  logic                             redirect_valid,
   input  logic [XLEN-1:0]                  redirect_pc,
   output logic                             fe_valid,
   input  logic                             fe_ready,
   output logic [XLEN-1:0]                  fe_instr,
   output logic [XLEN-1:0]                  fe_pc,
   output logic                             fe_first,
   output logic [$clog2(QDEPTH+1)-1:0]      fe_count
);
   localparam int CW = $clog2(QDEPTH+1);
   localparam int AW = $clog2(QDEPTH);

   logic [XLEN-1:0] pc, inflight_pc;
   logic            inflight, inflight_first, first_pending;
   logic [XLEN-1:0] q_instr [QDEPTH];
   logic [XLEN-1:0] q_pc    [QDEPTH];
   logic            q_first [QDEPTH];
   logic [AW-1:0]   head, tail;
   logic [CW-1:0]   count;
   logic [CW:0]     credit;
   logic            push, pop;

   // issue credit counts the outstanding response so the queue can never overflow
   always_comb begin
      credit    = {1'b0, count} + (CW+1)'(inflight);
      imem_req  = !reset && !redirect_valid && (credit < (CW+1)'(QDEPTH));
      imem_addr = pc;
      push      = inflight && !redirect_valid;
      fe_valid  = !reset && !redirect_valid && (count != '0);
      pop       = fe_valid && fe_ready;
      fe_instr  = q_instr[head];
      fe_pc     = q_pc[head];
      fe_first  = !reset && q_first[head];
      fe_count  = count;
   end

   // fetch pc, in-flight tracking and queue pointers; redirect overrides everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc             <= pc_init;
         inflight       <= 1'b0;
         inflight_pc    <= '0;
         inflight_first <= 1'b0;
         first_pending  <= 1'b1;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
      end else if (redirect_valid) begin
         pc            <= redirect_pc;
         inflight      <= 1'b0;
         first_pending <= 1'b1;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
      end else begin
         if (imem_req) begin
            pc             <= pc + XLEN'(4);
            inflight       <= 1'b1;
            inflight_pc    <= pc;
            inflight_first <= first_pending;
            first_pending  <= 1'b0;
         end else begin
            inflight <= 1'b0;
         end
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // queue storage is written from the returning response; contents need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[tail] <= imem_rdata;
         q_pc[tail]    <= inflight_pc;
         q_first[tail] <= inflight_first;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: randomized and directed checks of fetch_prefetch against a queue-based model
module tb_fetch_prefetch;
   localparam int QD = 4;

   logic        clk = 0, reset = 1;
   logic [31:0] pc_init = 0, imem_addr, imem_rdata = 0, redirect_pc = 0, fe_instr, fe_pc;
   logic        imem_req, redirect_valid = 0, fe_valid, fe_ready = 0, fe_first;
   logic [2:0]  fe_count;

   fetch_prefetch #(.XLEN(32), .QDEPTH(QD)) dut (
      .clk(clk), .reset(reset), .pc_init(pc_init), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_instr(fe_instr), .fe_pc(fe_pc),
      .fe_first(fe_first), .fe_count(fe_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic first;} ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc, m_ipc, key = 0, nxt_rdata;
   logic        m_inf, m_ifirst, m_fp, chk_en = 0;
   int          n_tests = 0, n_fail = 0;
   logic        o_req, o_valid, o_first;
   logic [31:0] o_addr, o_pc, o_instr;
   logic [2:0]  o_count;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic m_req();
      return !redirect_valid && (mq.size() + int'(m_inf) < QD);
   endfunction

   function automatic logic m_valid();
      return (mq.size() != 0) && !redirect_valid;
   endfunction

   // one clock of the model, evaluated with the inputs present at the edge
   task automatic model_step();
      logic req, vld;
      req = m_req();
      vld = m_valid();
      nxt_rdata = req ? (m_pc ^ key) : $urandom;
      if (redirect_valid) begin
         mq.delete();
         m_inf = 0;
         m_pc = redirect_pc;
         m_fp = 1;
      end else begin
         if (vld && fe_ready) void'(mq.pop_front());
         if (m_inf) mq.push_back('{imem_rdata, m_ipc, m_ifirst});
         if (req) begin
            m_inf = 1; m_ipc = m_pc; m_ifirst = m_fp; m_fp = 0; m_pc = m_pc + 32'd4;
         end else m_inf = 0;
      end
   endtask

   // compare process: every cycle, DUT outputs against the model
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_req", imem_req, 0);
         chk("rst_valid", fe_valid, 0);
         chk("rst_count", fe_count, 0);
         chk("rst_first", fe_first, 0);
      end else if (chk_en) begin
         chk("req", imem_req, m_req());
         if (m_req()) chk("addr", imem_addr, m_pc);
         chk("count", fe_count, mq.size());
         chk("valid", fe_valid, m_valid());
         if (m_valid()) begin
            chk("instr", fe_instr, mq[0].instr);
            chk("pc", fe_pc, mq[0].pc);
            chk("first", fe_first, mq[0].first);
         end
      end
   end

   task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv; redirect_pc = rpc; fe_ready = rdy;
      @(negedge clk);
      o_req = imem_req; o_addr = imem_addr; o_valid = fe_valid; o_pc = fe_pc;
      o_first = fe_first; o_count = fe_count; o_instr = fe_instr;
      @(posedge clk);
      model_step();
      #1;
      imem_rdata = nxt_rdata;
   endtask

   task automatic do_reset(input logic [31:0] pci);
      reset = 1; pc_init = pci; redirect_valid = 0; fe_ready = 0;
      mq.delete(); m_inf = 0; m_fp = 1; m_pc = pci;
      #1;
      chk("rst_now_req", imem_req, 0);
      chk("rst_now_valid", fe_valid, 0);
      chk("rst_now_count", fe_count, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 0; chk_en = 1;
   endtask

   initial begin
      do_reset(32'h1000);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 1);
         if (i == 0) begin chk("lit_addr0", o_addr, 32'h1000); chk("lit_req0", o_req, 1); end
         if (i >= 2) begin
            chk("lit_pc", o_pc, 32'h1000 + 32'(4 * (i - 2)));
            chk("lit_instr", o_instr, o_pc);
            chk("lit_first", o_first, i == 2);
         end
      end
      do_reset(32'h1000);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0);
      chk("lit_full_count", o_count, 4);
      chk("lit_full_req", o_req, 0);
      chk("lit_full_head", o_pc, 32'h1000);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 1);
         chk("lit_drain_valid", o_valid, 1);
         chk("lit_drain_pc", o_pc, 32'h1000 + 32'(4 * i));
      end
      do_reset(32'h1000);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0);
      chk("lit_pre_count", fe_count, 3);
      cyc(1, 32'h2000, 1);
      chk("lit_R_valid", o_valid, 0);
      chk("lit_R_req", o_req, 0);
      cyc(0, 0, 1);
      chk("lit_R1_count", o_count, 0);
      chk("lit_R1_addr", o_addr, 32'h2000);
      cyc(0, 0, 1);
      chk("lit_R2_valid", o_valid, 0);
      cyc(0, 0, 1);
      chk("lit_R3_valid", o_valid, 1);
      chk("lit_R3_pc", o_pc, 32'h2000);
      chk("lit_R3_first", o_first, 1);
      cyc(0, 0, 1);
      chk("lit_R4_pc", o_pc, 32'h2004);
      do_reset(32'hFFFF_FFF8);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 1);
         if (i >= 2) chk("lit_wrap_pc", o_pc, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
      end
      for (int i = 0; i < 8; i++) cyc(0, 0, 0);
      do_reset(32'h3000);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1);
         if (i == 0) chk("lit_rr_addr", o_addr, 32'h3000);
         if (i == 2) begin chk("lit_rr_pc", o_pc, 32'h3000); chk("lit_rr_first", o_first, 1); end
      end
      key = $urandom;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset($urandom);
         cyc($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
